// File: rtl/alu_sequencer.sv
// alu_sequencer: 3-state issue/exec/writeback controller for an 8-bit ALU with a 4x8 register file
// Ports: clk, rst_n (async active-low); instr_valid/instr_ready/instr/imm instruction handshake;
// load_en/load_sel/load_data external register write; rd_sel/rd_data debug read;
// alu_enable/alu_mode/alu_a/alu_b drive the ALU; alu_out/alu_zero/alu_carry come back from it;
// done retire pulse; flag_zero/flag_carry architectural flags.
`ifndef ALU_ADD
`define ALU_ADD 3'd0
`endif
`ifndef ALU_SUB
`define ALU_SUB 3'd1
`endif
`ifndef ALU_AND
`define ALU_AND 3'd2
`endif
`ifndef ALU_OR
`define ALU_OR 3'd3
`endif

module alu_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [7:0] instr,
  input  logic [7:0] imm,
  input  logic       load_en,
  input  logic [1:0] load_sel,
  input  logic [7:0] load_data,
  input  logic [1:0] rd_sel,
  output logic [7:0] rd_data,
  output logic       alu_enable,
  output logic [2:0] alu_mode,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic [7:0] alu_out,
  input  logic       alu_zero,
  input  logic       alu_carry,
  output logic       done,
  output logic       flag_zero,
  output logic       flag_carry
);
  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
  state_t state;
  logic [7:0] regs [4];
  logic [1:0] wb_rd;
  logic wb_en, arith;
  logic [1:0] op, rd, rs;
  logic [2:0] mode_n;
  assign op = instr[7:6];
  assign rd = instr[5:4];
  assign rs = instr[3:2];
  assign mode_n = op == 2'b00 ? `ALU_ADD : op == 2'b01 ? `ALU_SUB : op == 2'b10 ? `ALU_AND : `ALU_OR;
  assign rd_data = regs[rd_sel];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      for (int i = 0; i < 4; i++) regs[i] <= 8'h00;
      alu_a <= 8'h00;
      alu_b <= 8'h00;
      alu_mode <= `ALU_ADD;
      alu_enable <= 1'b0;
      done <= 1'b0;
      instr_ready <= 1'b1;
      flag_zero <= 1'b0;
      flag_carry <= 1'b0;
      wb_rd <= 2'd0;
      wb_en <= 1'b0;
      arith <= 1'b0;
    end else begin
      alu_enable <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          // operands below read pre-load values because all updates are non-blocking
          if (load_en) regs[load_sel] <= load_data;
          if (instr_valid && instr_ready) begin
            alu_a <= regs[rd];
            alu_b <= instr[1] ? imm : regs[rs];
            alu_mode <= mode_n;
            wb_rd <= rd;
            wb_en <= instr[0];
            arith <= ~op[1];
            alu_enable <= 1'b1;
            instr_ready <= 1'b0;
            state <= EXEC;
          end
        end
        EXEC: begin
          done <= 1'b1;
          state <= WB;
        end
        WB: begin
          if (wb_en) regs[wb_rd] <= alu_out;
          flag_zero <= alu_zero;
          // logic ops leave the ALU carry stale, so only arithmetic updates it
          if (arith) flag_carry <= alu_carry;
          instr_ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          instr_ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed self-checking bench for alu_sequencer with a behavioural ALU
`ifndef ALU_ADD
`define ALU_ADD 3'd0
`endif
`ifndef ALU_SUB
`define ALU_SUB 3'd1
`endif
`ifndef ALU_AND
`define ALU_AND 3'd2
`endif
`ifndef ALU_OR
`define ALU_OR 3'd3
`endif

module tb_alu_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic instr_valid = 1'b0;
  logic instr_ready;
  logic [7:0] instr = 8'h00;
  logic [7:0] imm = 8'h00;
  logic load_en = 1'b0;
  logic [1:0] load_sel = 2'd0;
  logic [7:0] load_data = 8'h00;
  logic [1:0] rd_sel = 2'd0;
  logic [7:0] rd_data;
  logic alu_enable;
  logic [2:0] alu_mode;
  logic [7:0] alu_a, alu_b;
  logic [7:0] alu_out = 8'h00;
  logic alu_zero = 1'b0;
  logic alu_carry = 1'b0;
  logic done, flag_zero, flag_carry;
  int errors = 0;
  int checks = 0;

  alu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .imm(imm), .load_en(load_en), .load_sel(load_sel), .load_data(load_data),
    .rd_sel(rd_sel), .rd_data(rd_data), .alu_enable(alu_enable), .alu_mode(alu_mode),
    .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out), .alu_zero(alu_zero),
    .alu_carry(alu_carry), .done(done), .flag_zero(flag_zero), .flag_carry(flag_carry)
  );

  always #5 clk = ~clk;

  // ALU model: samples on enable, result valid the following cycle; logic ops drive carry 0
  always @(posedge clk) begin
    logic [8:0] r;
    if (alu_enable) begin
      r = 9'h000;
      if (alu_mode == `ALU_ADD) r = {1'b0, alu_a} + {1'b0, alu_b};
      else if (alu_mode == `ALU_SUB) r = {1'b0, alu_a} - {1'b0, alu_b};
      else if (alu_mode == `ALU_AND) r = {1'b0, alu_a & alu_b};
      else r = {1'b0, alu_a | alu_b};
      alu_out <= r[7:0];
      alu_carry <= r[8];
      alu_zero <= r[7:0] == 8'h00;
    end
  end

  task automatic read_reg(input logic [1:0] sel, output logic [7:0] val);
    rd_sel = sel;
    #1;
    val = rd_data;
  endtask

  task automatic do_load(input logic [1:0] sel, input logic [7:0] data);
    @(negedge clk);
    load_en = 1'b1;
    load_sel = sel;
    load_data = data;
    @(posedge clk);
    #1;
    load_en = 1'b0;
  endtask

  // accept at T0, count negedges until done; returns #1 after the retiring edge
  task automatic issue(input logic [7:0] ins, input logic [7:0] im, output int lat);
    @(negedge clk);
    instr_valid = 1'b1;
    instr = ins;
    imm = im;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    lat = 99;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (done) begin
        lat = c;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    instr_valid = 1'b0;
    load_en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    do_reset();
    @(negedge clk);
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", instr_ready); end
    checks++; if ({done, alu_enable, flag_zero, flag_carry} !== 4'b0000) begin errors++; $display("FAIL reset_ctl got=%b exp=0000", {done, alu_enable, flag_zero, flag_carry}); end
    checks++; if ({alu_mode, alu_a, alu_b} !== {`ALU_ADD, 16'h0000}) begin errors++; $display("FAIL reset_alu got=%h/%h/%h exp=%h/00/00", alu_mode, alu_a, alu_b, `ALU_ADD); end
    for (int i = 0; i < 4; i++) begin
      read_reg(i[1:0], v);
      checks++; if (v !== 8'h00) begin errors++; $display("FAIL reset_reg%0d got=%h exp=00", i, v); end
    end
  endtask

  task automatic test_add_carry();
    int lat;
    logic [7:0] v;
    do_load(2'd1, 8'h80);
    do_load(2'd2, 8'h80);
    issue(8'b00_01_10_0_1, 8'h00, lat);
    checks++; if (lat != 2) begin errors++; $display("FAIL add_latency got=%0d exp=2", lat); end
    read_reg(2'd1, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL add_r1 got=%h exp=00", v); end
    checks++; if ({flag_zero, flag_carry} !== 2'b11) begin errors++; $display("FAIL add_flags got=%b exp=11", {flag_zero, flag_carry}); end
  endtask

  task automatic test_sub_imm();
    int lat;
    logic [7:0] v;
    do_load(2'd0, 8'h05);
    issue(8'b01_00_00_1_1, 8'h07, lat);
    read_reg(2'd0, v);
    checks++; if (v !== 8'hFE) begin errors++; $display("FAIL sub1_r0 got=%h exp=fe", v); end
    checks++; if ({flag_zero, flag_carry} !== 2'b01) begin errors++; $display("FAIL sub1_flags got=%b exp=01", {flag_zero, flag_carry}); end
    issue(8'b01_00_00_1_1, 8'hFE, lat);
    read_reg(2'd0, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL sub2_r0 got=%h exp=00", v); end
    checks++; if ({flag_zero, flag_carry} !== 2'b10) begin errors++; $display("FAIL sub2_flags got=%b exp=10", {flag_zero, flag_carry}); end
  endtask

  task automatic test_logic_flags();
    int lat;
    logic [7:0] v;
    do_load(2'd1, 8'hFF);
    do_load(2'd2, 8'h02);
    issue(8'b00_01_10_0_0, 8'h00, lat);
    checks++; if ({flag_zero, flag_carry} !== 2'b01) begin errors++; $display("FAIL prime_flags got=%b exp=01", {flag_zero, flag_carry}); end
    do_load(2'd3, 8'hF0);
    do_load(2'd2, 8'h0F);
    issue(8'b10_11_10_0_0, 8'h00, lat);
    read_reg(2'd3, v);
    checks++; if (v !== 8'hF0) begin errors++; $display("FAIL and_r3 got=%h exp=f0", v); end
    checks++; if ({flag_zero, flag_carry} !== 2'b11) begin errors++; $display("FAIL and_flags got=%b exp=11", {flag_zero, flag_carry}); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] list [3];
    logic [7:0] imms [3];
    int acc [3];
    int n = 0, en_cnt = 0, done_cnt = 0, consec = 0;
    logic prev_en = 1'b0;
    logic [7:0] v;
    list[0] = 8'b11_00_01_0_1; imms[0] = 8'h00;
    list[1] = 8'b11_00_10_0_1; imms[1] = 8'h00;
    list[2] = 8'b11_00_00_1_1; imms[2] = 8'h80;
    do_load(2'd0, 8'h01);
    do_load(2'd1, 8'h02);
    do_load(2'd2, 8'h04);
    @(negedge clk);
    instr_valid = 1'b1;
    instr = list[0];
    imm = imms[0];
    for (int c = 0; c < 14; c++) begin
      if (c > 0) @(negedge clk);
      if (alu_enable) begin en_cnt++; if (prev_en) consec++; end
      prev_en = alu_enable;
      if (done) done_cnt++;
      if (instr_valid && instr_ready) begin
        acc[n] = c;
        n++;
        @(posedge clk);
        #1;
        if (n < 3) begin instr = list[n]; imm = imms[n]; end
        else instr_valid = 1'b0;
      end
    end
    checks++; if (n != 3) begin errors++; $display("FAIL b2b_accepts got=%0d exp=3", n); end
    else begin
      checks++; if (acc[1] - acc[0] != 3 || acc[2] - acc[1] != 3) begin errors++; $display("FAIL b2b_spacing got=%0d,%0d exp=3,3", acc[1] - acc[0], acc[2] - acc[1]); end
    end
    checks++; if (done_cnt != 3) begin errors++; $display("FAIL b2b_done got=%0d exp=3", done_cnt); end
    checks++; if (en_cnt != 3 || consec != 0) begin errors++; $display("FAIL b2b_enable got=%0d consec=%0d exp=3 consec=0", en_cnt, consec); end
    read_reg(2'd0, v);
    checks++; if (v !== 8'h87) begin errors++; $display("FAIL b2b_r0 got=%h exp=87", v); end
    checks++; if ({flag_zero, flag_carry} !== 2'b01) begin errors++; $display("FAIL b2b_flags got=%b exp=01", {flag_zero, flag_carry}); end
  endtask

  task automatic test_reset_mid();
    int lat, dn = 0;
    logic [7:0] v;
    do_load(2'd1, 8'h20);
    @(negedge clk);
    instr_valid = 1'b1;
    instr = 8'b00_01_00_1_1;
    imm = 8'h01;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(negedge clk);
    checks++; if (alu_enable !== 1'b1) begin errors++; $display("FAIL mid_exec_enable got=%b exp=1", alu_enable); end
    rst_n = 1'b0;
    #2;
    checks++; if ({done, alu_enable, flag_zero, flag_carry} !== 4'b0000) begin errors++; $display("FAIL mid_ctl got=%b exp=0000", {done, alu_enable, flag_zero, flag_carry}); end
    for (int i = 0; i < 4; i++) begin
      read_reg(i[1:0], v);
      checks++; if (v !== 8'h00) begin errors++; $display("FAIL mid_reg%0d got=%h exp=00", i, v); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done) dn++;
    end
    checks++; if (dn != 0 || instr_ready !== 1'b1) begin errors++; $display("FAIL mid_after done=%0d ready=%b exp done=0 ready=1", dn, instr_ready); end
    do_load(2'd2, 8'h03);
    issue(8'b00_10_00_1_1, 8'h04, lat);
    read_reg(2'd2, v);
    checks++; if (lat != 2 || v !== 8'h07) begin errors++; $display("FAIL mid_next lat=%0d r2=%h exp lat=2 r2=07", lat, v); end
  endtask

  task automatic test_load_collision();
    logic [7:0] v;
    do_load(2'd1, 8'h20);
    @(negedge clk);
    load_en = 1'b1; load_sel = 2'd1; load_data = 8'h10;
    instr_valid = 1'b1; instr = 8'b00_01_00_1_1; imm = 8'h01;
    @(posedge clk);
    #1;
    load_en = 1'b0;
    instr_valid = 1'b0;
    read_reg(2'd1, v);
    checks++; if (v !== 8'h10) begin errors++; $display("FAIL coll_load got=%h exp=10", v); end
    checks++; if (alu_a !== 8'h20) begin errors++; $display("FAIL coll_opa got=%h exp=20", alu_a); end
    @(negedge clk);
    load_en = 1'b1; load_sel = 2'd3; load_data = 8'h55;
    @(posedge clk);
    #1;
    load_en = 1'b0;
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL coll_done got=%b exp=1", done); end
    @(posedge clk);
    #1;
    read_reg(2'd1, v);
    checks++; if (v !== 8'h21) begin errors++; $display("FAIL coll_r1 got=%h exp=21", v); end
    read_reg(2'd3, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL coll_exec_load got=%h exp=00", v); end
  endtask

  initial begin
    test_reset();
    test_add_carry();
    test_sub_imm();
    test_logic_flags();
    test_back_to_back();
    test_reset_mid();
    do_reset();
    test_load_collision();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Control stage directly upstream of the 8-bit ALU. It accepts one instruction at a time over a valid/ready handshake and holds a 4×8-bit register file. For each instruction it latches the operands, pulses the ALU enable for one cycle, then writes the ALU result back and captures the flags. It owns the ALU's `enable`, `mode`, `in_a` and `in_b` inputs, and consumes the ALU's `out`, `flag_zero` and `flag_carry`.

## Interface
- No parameters. Data width is 8 bits, there are 4 registers, and ALU mode codes come from the shared `ALU_*` macros.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `instr_valid` in 1: an instruction is present.
- `instr_ready` out 1: the sequencer can accept an instruction this cycle.
- `instr` in 8: instruction word.
  - [7:6] op: 00 ADD, 01 SUB, 10 AND, 11 OR.
  - [5:4] rd: destination register and operand A.
  - [3:2] rs: operand B register.
  - [1] use_imm: take operand B from `imm` instead of `rs`.
  - [0] wb_en: write the result back to rd.
- `imm` in 8: immediate operand, sampled at accept.
- `load_en` in 1: external register write request.
- `load_sel` in 2: register written by a load.
- `load_data` in 8: value written by a load.
- `rd_sel` in 2: debug read select.
- `rd_data` out 8: combinational read of `regs[rd_sel]`.
- `alu_enable` out 1: drives the ALU `enable`.
- `alu_mode` out 3: drives the ALU `mode`.
- `alu_a` out 8: drives the ALU `in_a`.
- `alu_b` out 8: drives the ALU `in_b`.
- `alu_out` in 8: the ALU `out`.
- `alu_zero` in 1: the ALU `flag_zero`.
- `alu_carry` in 1: the ALU `flag_carry`.
- `done` out 1: one-cycle pulse when an instruction retires.
- `flag_zero` out 1: architectural zero flag.
- `flag_carry` out 1: architectural carry/borrow flag.

## Operation
- **States:** IDLE, EXEC, WB. There are no other states; any illegal encoding goes to IDLE.
- **IDLE:**
  - `instr_ready`=1.
  - An instruction is accepted when `instr_valid` and `instr_ready` are both high at a rising edge.
  - At accept, the block registers:
    - `alu_a` = `regs[rd]`;
    - `alu_b` = `imm` if use_imm, else `regs[rs]`;
    - `alu_mode` = the `ALU_*` code for op;
    - rd, wb_en, and the op class (arithmetic vs. logic).
  - The next state is EXEC.
- **EXEC:**
  - `alu_enable`=1 for exactly this cycle; `alu_a`, `alu_b` and `alu_mode` are held stable.
  - The ALU samples its inputs at the closing edge. The next state is WB.
- **WB:**
  - `alu_out`, `alu_zero` and `alu_carry` are valid here. At the closing edge:
    - if wb_en, `regs[rd]` ← `alu_out`;
    - `flag_zero` ← `alu_zero`;
    - `flag_carry` ← `alu_carry` only for ADD/SUB. For AND/OR, `flag_carry` keeps its previous value, because the ALU's carry is stale for logic ops.
  - `done`=1 during WB. The next state is IDLE.
- **Arithmetic:** all arithmetic is performed in the ALU.
  - ADD carry = bit 8 of the 9-bit sum.
  - SUB carry = borrow, i.e. bit 8 of the 9-bit difference, which is 1 when a < b.
  - Results wrap modulo 256.
- **Load port:**
  - A load is honoured only in IDLE, writing `regs[load_sel]` ← `load_data` at the edge. In EXEC and WB it is ignored, not queued.
  - Load and accept on the same edge: both happen. The instruction's operands see the pre-load register values.
- **Write conflict:** a load and a WB write to the same register cannot collide, because loads are blocked outside IDLE.
- **Debug read:** `rd_data` reflects register writes from the cycle after the writing edge.

## Timing
- **Reset values** (asynchronous on `rst_n`=0):
  - state = IDLE;
  - all `regs` = 0x00;
  - `alu_a`=`alu_b`=0x00, `alu_mode`=`ALU_ADD`;
  - `alu_enable`=0, `done`=0;
  - `flag_zero`=0, `flag_carry`=0;
  - `instr_ready`=1 once reset is released.
- **Reset mid-instruction:** the instruction is abandoned, with no writeback and no `done`. The ALU's own stale `out` and flags are ignored until the next WB.
- **Latency:** the accept edge is T0; EXEC spans T0→T1; WB spans T1→T2. `done` is high in the cycle between T1 and T2, and the register/flag update is visible after T2.
- **Throughput:** one instruction per 3 cycles. With `instr_valid` held high, accepts occur at T0, T0+3, T0+6, and so on.
- **Ready timing:** `instr_ready` is a registered state decode; it is 0 in EXEC and WB.
- **Enable timing:** `alu_enable` is never high for two consecutive cycles.

## Test plan
- **ADD with carry out:** after reset, load r1=0x80 and r2=0x80, then issue ADD rd=1, rs=2, wb_en=1 → `done` 2 cycles after accept; r1=0x00, Z=1, C=1.
- **SUB with immediate:** load r0=0x05; SUB rd=0, use_imm=1, imm=0x07, wb_en=1 → r0=0xFE, Z=0, C=1. Then SUB rd=0, imm=0xFE → r0=0x00, Z=1, C=0.
- **Logic op, flags only:** set C=1 by a prior ADD; then r3=0xF0, r2=0x0F, AND rd=3, rs=2, wb_en=0 → r3 stays 0xF0, Z=1, C stays 1.
- **Back-to-back:** hold `instr_valid` high across 3 ORs → accepts exactly 3 cycles apart, 3 `done` pulses, `alu_enable` high exactly 3 single cycles.
- **Reset mid-instruction:** assert `rst_n`=0 during EXEC of ADD r1 → no `done`; all registers and flags 0; `instr_ready`=1 after release; the next instruction executes normally.
- **Load collisions:** a load r1=0x10 on the same edge as accepting ADD rd=1, imm=0x01 (old r1=0x20) → r1 ends 0x21, since the WB overwrites the load. A load issued during EXEC is ignored.
